// File: rtl/inj_src_packet_buffer.sv
// inj_src_packet_buffer
// Elastic, packet-aware flit buffer placed in front of a TaskInjector source port.
// Host flits enter through a credit handshake. They are stored in a first-word-fall-through
// FIFO and re-issued to the injector with the same credit handshake. A passive framer watches
// the accepted stream and reports packet statistics.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   src_rx_i      host flit valid
//   src_credit_o  buffer can accept a flit this cycle
//   src_data_i    host flit
//   inj_tx_o      flit valid toward the injector
//   inj_credit_i  injector accepts the presented flit
//   inj_data_o    head flit, or 0 when the FIFO is empty
//   level_o       current FIFO occupancy
//   pkt_count_o   completed packets accepted from the host; wraps
//   size_err_o    sticky: a size flit exceeded MAX_PAYLOAD
//   frame_state_o input framer state (00 HDR, 01 SIZE, 10 PAYLOAD)
module inj_src_packet_buffer #(
    parameter int unsigned FLIT_SIZE   = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned MAX_PAYLOAD = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       src_rx_i,
    output logic                       src_credit_o,
    input  logic [FLIT_SIZE-1:0]       src_data_i,
    output logic                       inj_tx_o,
    input  logic                       inj_credit_i,
    output logic [FLIT_SIZE-1:0]       inj_data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [15:0]                pkt_count_o,
    output logic                       size_err_o,
    output logic [1:0]                 frame_state_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] ST_HDR     = 2'b00;
    localparam logic [1:0] ST_SIZE    = 2'b01;
    localparam logic [1:0] ST_PAYLOAD = 2'b10;

    localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
    localparam logic [FLIT_SIZE-1:0] MAX_PL  = FLIT_SIZE'(MAX_PAYLOAD);

    // FIFO storage and pointers (extra MSB is the wrap bit)
    logic [FLIT_SIZE-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 full, empty, push, pop;

    // Framer state
    logic [1:0]  state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        size_err_q, size_err_d;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // Credit depends only on registered state and reset, never on src_rx_i
    assign src_credit_o = ~full & ~rst_i;
    assign push         = src_rx_i & src_credit_o;

    assign inj_tx_o   = ~empty;
    assign pop        = inj_tx_o & inj_credit_i;
    assign inj_data_o = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    assign level_o       = wr_ptr_q - rd_ptr_q;
    assign pkt_count_o   = pkt_count_q;
    assign size_err_o    = size_err_q;
    assign frame_state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= src_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Framer follows accepted host flits only; it never alters or stalls the stream
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pkt_count_d = pkt_count_q;
        size_err_d  = size_err_q;
        if (push) begin
            case (state_q)
                ST_HDR: begin
                    state_d = ST_SIZE;
                end
                ST_SIZE: begin
                    remaining_d = src_data_i[15:0];
                    if (src_data_i > MAX_PL) begin
                        size_err_d = 1'b1;
                    end
                    if (src_data_i[15:0] == 16'd0) begin
                        state_d     = ST_HDR;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d     = ST_HDR;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
            pkt_count_q <= '0;
            size_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pkt_count_q <= pkt_count_d;
            size_err_q  <= size_err_d;
        end
    end

endmodule

// File: tb/tb_inj_src_packet_buffer.sv
// tb_inj_src_packet_buffer
// Self-checking bench for inj_src_packet_buffer: a table of directed vectors, hand-written
// corner-case sequences and a randomized run checked against a queue-based reference model.
module tb_inj_src_packet_buffer;

    localparam int DEPTH = 16;
    localparam int MAXP  = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, src_rx, src_credit, inj_tx, inj_credit, size_err;
    logic [31:0]   src_data, inj_data;
    logic [LW-1:0] level;
    logic [15:0]   pkt_count;
    logic [1:0]    frame_state;

    always #5 clk = ~clk;

    inj_src_packet_buffer #(
        .FLIT_SIZE   (32),
        .DEPTH       (DEPTH),
        .MAX_PAYLOAD (MAXP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .src_rx_i      (src_rx),
        .src_credit_o  (src_credit),
        .src_data_i    (src_data),
        .inj_tx_o      (inj_tx),
        .inj_credit_i  (inj_credit),
        .inj_data_o    (inj_data),
        .level_o       (level),
        .pkt_count_o   (pkt_count),
        .size_err_o    (size_err),
        .frame_state_o (frame_state)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: stored flits, and position within the current packet
    logic [31:0] mq[$];
    int          m_idx;   // flits of the current packet accepted so far
    int          m_plen;  // total packet length once the size flit is known
    logic [15:0] m_pkts;
    logic        m_err;

    logic [31:0] recv[$];
    bit          chk_en;
    bit          last_push;

    // Outputs sampled at the falling edge of the latest cycle
    logic        s_credit, s_tx, s_err;
    logic [31:0] s_data;
    logic [LW-1:0] s_level;
    logic [15:0] s_pc;
    logic [1:0]  s_fs;

    typedef struct {
        logic        rx;
        logic [31:0] data;
        logic        exp_tx;
        logic [31:0] exp_data;
        logic [15:0] exp_pc;
        logic [1:0]  exp_fs;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_fs();
        if (m_idx == 0) return 2'b00;
        if (m_idx == 1) return 2'b01;
        return 2'b10;
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, advance the model at the rise
    task automatic cyc(input logic r, input logic rx, input logic cr, input logic [31:0] d);
        logic        mc, mt, mpush, mpop;
        logic [31:0] md;
        rst        = r;
        src_rx     = rx;
        inj_credit = cr;
        src_data   = d;
        @(negedge clk);
        mc = (mq.size() < DEPTH) && !r;
        mt = (mq.size() != 0);
        md = mt ? mq[0] : 32'h0;
        s_credit = src_credit;
        s_tx     = inj_tx;
        s_data   = inj_data;
        s_level  = level;
        s_pc     = pkt_count;
        s_err    = size_err;
        s_fs     = frame_state;
        if (chk_en) begin
            check("src_credit", 32'(src_credit), 32'(mc));
            check("inj_tx", 32'(inj_tx), 32'(mt));
            check("inj_data", inj_data, md);
            check("level", 32'(level), 32'(mq.size()));
            check("pkt_count", 32'(pkt_count), 32'(m_pkts));
            check("size_err", 32'(size_err), 32'(m_err));
            check("frame_state", 32'(frame_state), 32'(model_fs()));
        end
        if (inj_tx === 1'b1 && cr) recv.push_back(inj_data);
        mpush = rx && mc;
        mpop  = mt && cr;
        last_push = mpush;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_idx  = 0;
            m_plen = 0;
            m_pkts = '0;
            m_err  = 1'b0;
        end else begin
            if (mpop) void'(mq.pop_front());
            if (mpush) begin
                mq.push_back(d);
                if (m_idx == 1) begin
                    m_plen = 2 + int'(d[15:0]);
                    if (d > 32'(MAXP)) m_err = 1'b1;
                end
                m_idx++;
                if (m_idx >= 2 && m_idx == m_plen) begin
                    m_pkts = m_pkts + 16'd1;
                    m_idx  = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        int          n;
        int          g_idx, g_len, thr;
        logic [31:0] d;
        logic        r;

        rst = 1'b1; src_rx = 1'b0; inj_credit = 1'b0; src_data = '0;
        m_idx = 0; m_plen = 0; m_pkts = '0; m_err = 1'b0;
        chk_en = 1'b0;
        @(posedge clk);
        #1;

        // Reset: state unknown before the first edge, checked afterwards
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk_en = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        check("credit_in_reset", 32'(s_credit), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("credit_after_reset", 32'(s_credit), 32'h1);
        check("level_after_reset", 32'(s_level), 32'h0);
        check("tx_after_reset", 32'(s_tx), 32'h0);

        // Basic packet: hdr, size 3, three payloads with the injector always ready
        tbl[0] = '{1'b1, 32'h0000_0102, 1'b0, 32'h0,          16'd0, 2'b00};
        tbl[1] = '{1'b1, 32'h0000_0003, 1'b1, 32'h0000_0102, 16'd0, 2'b01};
        tbl[2] = '{1'b1, 32'hAAAA_0001, 1'b1, 32'h0000_0003, 16'd0, 2'b10};
        tbl[3] = '{1'b1, 32'hBBBB_0002, 1'b1, 32'hAAAA_0001, 16'd0, 2'b10};
        tbl[4] = '{1'b1, 32'hCCCC_0003, 1'b1, 32'hBBBB_0002, 16'd0, 2'b10};
        tbl[5] = '{1'b0, 32'h0,         1'b1, 32'hCCCC_0003, 16'd1, 2'b00};
        tbl[6] = '{1'b0, 32'h0,         1'b0, 32'h0,          16'd1, 2'b00};
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, tbl[i].rx, 1'b1, tbl[i].data);
            check($sformatf("tbl%0d_tx", i), 32'(s_tx), 32'(tbl[i].exp_tx));
            check($sformatf("tbl%0d_data", i), s_data, tbl[i].exp_data);
            check($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].exp_pc));
            check($sformatf("tbl%0d_fs", i), 32'(s_fs), 32'(tbl[i].exp_fs));
        end

        // Fill with the injector stalled, then one cycle of push+pop while full
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        recv.delete();
        n = 0;
        for (int k = 0; k < 25; k++) begin
            cyc(1'b0, n < 20, 1'b0, 32'hA000_0000 + 32'(n));
            if (last_push) n++;
        end
        check("full_level", 32'(s_level), 32'd16);
        check("full_credit", 32'(s_credit), 32'h0);
        check("full_head_stable", s_data, 32'hA000_0000);
        check("full_push_count", 32'(n), 32'd16);
        cyc(1'b0, 1'b1, 1'b1, 32'hA000_0000 + 32'(n));
        if (last_push) n++;
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("after_full_pop_level", 32'(s_level), 32'd15);
        check("after_full_pop_credit", 32'(s_credit), 32'h1);
        for (int k = 0; k < 60 && (n < 20 || mq.size() != 0); k++) begin
            cyc(1'b0, n < 20, 1'b1, 32'hA000_0000 + 32'(n));
            if (last_push) n++;
        end
        check("stream_count", 32'(recv.size()), 32'd20);
        for (int i = 0; i < 20 && i < recv.size(); i++) begin
            check($sformatf("stream%0d", i), recv[i], 32'hA000_0000 + 32'(i));
        end

        // Zero-size packet, next flit must be treated as a header
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0055);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0000);
        check("zero_fs_size", 32'(s_fs), 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0077);
        check("zero_fs_hdr", 32'(s_fs), 32'h0);
        check("zero_pc", 32'(s_pc), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("zero_next_is_hdr", 32'(s_fs), 32'h1);

        // Oversize packet: size 33, still fully forwarded
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        recv.delete();
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        cyc(1'b0, 1'b1, 1'b1, 32'd33);
        check("err_before", 32'(s_err), 32'h0);
        for (int i = 0; i < 33; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'h5000_0000 + 32'(i));
            if (i == 0) check("err_set", 32'(s_err), 32'h1);
        end
        for (int k = 0; k < 20 && mq.size() != 0; k++) cyc(1'b0, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("err_sticky", 32'(s_err), 32'h1);
        check("err_pc", 32'(s_pc), 32'h1);
        check("err_forwarded", 32'(recv.size()), 32'd35);

        // Reset mid-payload with five flits buffered
        cyc(1'b0, 1'b1, 1'b0, 32'h0000_0300);
        cyc(1'b0, 1'b1, 1'b0, 32'd10);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h6000_0000 + 32'(i));
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("mid_level", 32'(s_level), 32'd5);
        check("mid_fs", 32'(s_fs), 32'h2);
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("rst_tx", 32'(s_tx), 32'h0);
        check("rst_level", 32'(s_level), 32'h0);
        check("rst_fs", 32'(s_fs), 32'h0);
        check("rst_pc", 32'(s_pc), 32'h0);
        check("rst_err", 32'(s_err), 32'h0);

        // Randomized packet traffic with phases of heavy and light back-pressure
        g_idx = 0;
        g_len = 0;
        for (int k = 0; k < 1500; k++) begin
            thr = ((k / 100) % 2 == 0) ? 20 : 90;
            r   = ($urandom_range(0, 249) == 0);
            if (g_idx == 1) d = 32'($urandom_range(0, 40));
            else            d = $urandom;
            cyc(r, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < thr, d);
            if (r) begin
                g_idx = 0;
            end else if (last_push) begin
                if (g_idx == 1) g_len = 2 + int'(d[15:0]);
                g_idx++;
                if (g_idx >= 2 && g_idx == g_len) g_idx = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
